// File: rtl/global_types.sv
// Project-wide scalar type aliases shared by every pipeline block.
package global_types;

  typedef logic [31:0] logic32;

endpackage

// File: rtl/pipeline_pkg.sv
// Pipeline-wide types: fetch FSM states and the prefetch FIFO entry layout.
package pipeline_pkg;
  import global_types::*;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  // One prefetched instruction together with the PC+4 that decode expects.
  typedef struct packed {
    logic32 instruction;
    logic32 pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface fetch_unit_if;
  import global_types::*;

  logic   imem_req;
  logic32 imem_addr;
  logic   imem_gnt;
  logic   imem_rvalid;
  logic32 imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: power-of-two depth, extra pointer bit separates full from empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot, so a simultaneous push is accepted even when full.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request stream, in-order response tracking,
// redirect flush of stale responses; FIFO storage lives in fetch_fifo.
module fetch_unit
  import global_types::*;
  import pipeline_pkg::*;
#(
  parameter int     DEPTH    = 4,
  parameter logic32 RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rstn,
  fetch_unit_if.master imem,
  input  logic         d_ready,
  output logic         f_valid,
  output logic32       f_instruction,
  output logic32       f_pc_plus4,
  input  logic         redirect,
  input  logic32       redirect_pc
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_t  state;
  logic32        fetch_pc;
  logic32        rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic          req_q;

  logic          accept;
  logic          rvalid;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] out_next;
  logic [CW-1:0] cnt_next;
  logic          credit_ok;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = fetch_pc;

  assign accept    = req_q & imem.imem_gnt;
  assign rvalid    = imem.imem_rvalid;
  assign fifo_push = rvalid && (state == FETCH) && !redirect;
  assign fifo_pop  = f_valid & d_ready;

  // rsp_pc tracks the address of the oldest live request, since responses return in order.
  assign push_entry = '{instruction: imem.imem_rdata, pc_plus4: rsp_pc + 32'd4};

  assign out_next  = outstanding + CW'(accept) - CW'(rvalid);
  assign cnt_next  = redirect ? '0 : fifo_count + CW'(fifo_push) - CW'(fifo_pop);
  // Every request must have a guaranteed FIFO slot waiting for its response.
  assign credit_ok = ({1'b0, cnt_next} + {1'b0, out_next}) < DEPTH_W;

  assign f_valid       = !fifo_empty;
  assign f_instruction = head_entry.instruction;
  assign f_pc_plus4    = head_entry.pc_plus4;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (redirect),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      req_q       <= 1'b0;
    end else begin
      outstanding <= out_next;
      req_q       <= 1'b0;
      if (redirect) begin
        // A grant in this cycle is already in out_next and will be dropped with the rest.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= out_next;
        if (out_next != '0) begin
          state <= FLUSH;
        end else begin
          state <= FETCH;
          req_q <= credit_ok;
        end
      end else begin
        case (state)
          FETCH: begin
            req_q <= credit_ok;
            if (accept)    fetch_pc <= fetch_pc + 32'd4;
            if (fifo_push) rsp_pc   <= rsp_pc + 32'd4;
          end
          FLUSH: begin
            if (rvalid) begin
              drop_cnt <= drop_cnt - CW'(1);
              if (drop_cnt == CW'(1)) begin
                state <= FETCH;
                req_q <= credit_ok;
              end
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rstn) rvalid |-> (outstanding != '0));

  a_fifo_no_overflow: assert property (
    @(posedge clk) disable iff (!rstn) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, multi-cycle
// redirect/reset sequences and a randomised scoreboard run.
module tb_fetch_unit;
  import global_types::*;

  localparam int DEPTH = 4;

  logic   clk = 1'b0;
  logic   rstn = 1'b0;
  logic   d_ready = 1'b1;
  logic   redirect = 1'b0;
  logic32 redirect_pc = '0;
  logic   f_valid;
  logic32 f_instruction;
  logic32 f_pc_plus4;

  fetch_unit_if mem_if ();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .imem          (mem_if),
    .d_ready       (d_ready),
    .f_valid       (f_valid),
    .f_instruction (f_instruction),
    .f_pc_plus4    (f_pc_plus4),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic   d_ready;
    logic   exp_req;
    logic32 exp_addr;
    logic   exp_fvalid;
    logic32 exp_pc4;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     lat = 1;
  int     pops = 0;
  bit     rand_mode = 1'b0;
  bit     sb_en = 1'b0;
  logic32 exp_pc = '0;
  logic32 pend_addr[$];
  int     pend_due[$];
  vec_t   vecs[21];

  function automatic logic32 instr_of(logic32 a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic vec_t mk(logic dr, logic rq, logic32 ad, logic fv, logic32 p4);
    vec_t v;
    v.d_ready = dr; v.exp_req = rq; v.exp_addr = ad; v.exp_fvalid = fv; v.exp_pc4 = p4;
    return v;
  endfunction

  task automatic check(string name, logic32 act, logic32 exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic present_rsp();
    mem_if.imem_rvalid = (pend_addr.size() > 0) && (pend_due[0] <= cyc) &&
                         (!rand_mode || $urandom_range(0, 3) != 0);
    mem_if.imem_rdata  = mem_if.imem_rvalid ? instr_of(pend_addr[0]) : '0;
  endtask

  // One clock: sample handshakes at negedge, advance the memory model after the edge.
  task automatic tick();
    logic   acc;
    logic   taken;
    logic32 acc_addr;
    @(negedge clk);
    acc      = mem_if.imem_req & mem_if.imem_gnt;
    acc_addr = mem_if.imem_addr;
    taken    = mem_if.imem_rvalid;
    if (sb_en) begin
      if (f_valid && d_ready) begin
        check("sb_pc_plus4", f_pc_plus4, exp_pc + 32'd4);
        check("sb_instruction", f_instruction, instr_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end else if (!f_valid) begin
        check("idle_pc_plus4_zero", f_pc_plus4, '0);
        check("idle_instruction_zero", f_instruction, '0);
      end
      if (redirect) exp_pc = redirect_pc;
      check("occupancy_over_depth", 32'(dut.fifo_count > DEPTH), 32'd0);
      check("credit_over_depth", 32'((int'(dut.fifo_count) + pend_addr.size()) > DEPTH), 32'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (taken) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (acc) begin
      pend_addr.push_back(acc_addr);
      pend_due.push_back(cyc + (rand_mode ? int'($urandom_range(1, 4)) : lat) - 1);
    end
    present_rsp();
    if (rand_mode) begin
      mem_if.imem_gnt = ($urandom_range(0, 2) != 0);
      d_ready         = ($urandom_range(0, 3) != 0);
      redirect        = ($urandom_range(0, 29) == 0);
      redirect_pc     = $urandom & 32'h0000_FFFC;
    end
  endtask

  task automatic clear_mem();
    pend_addr.delete();
    pend_due.delete();
    mem_if.imem_rvalid = 1'b0;
    mem_if.imem_rdata  = '0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    redirect = 1'b0;
    d_ready = 1'b1;
    mem_if.imem_gnt = 1'b1;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic wait_fvalid(string name);
    for (int i = 0; i < 30 && !f_valid; i++) tick();
    check(name, 32'(f_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(1, 1, 32'd0,  0, 32'd0);
    vecs[1]  = mk(1, 1, 32'd4,  0, 32'd0);
    vecs[2]  = mk(1, 1, 32'd8,  1, 32'd4);
    vecs[3]  = mk(1, 1, 32'd12, 1, 32'd8);
    vecs[4]  = mk(1, 1, 32'd16, 1, 32'd12);
    vecs[5]  = mk(1, 1, 32'd20, 1, 32'd16);
    vecs[6]  = mk(0, 1, 32'd24, 1, 32'd16);
    for (int i = 7; i < 16; i++) vecs[i] = mk(0, 0, 32'd28, 1, 32'd16);
    vecs[16] = mk(1, 1, 32'd28, 1, 32'd20);
    vecs[17] = mk(1, 1, 32'd32, 1, 32'd24);
    vecs[18] = mk(1, 1, 32'd36, 1, 32'd28);
    vecs[19] = mk(1, 1, 32'd40, 1, 32'd32);
    vecs[20] = mk(1, 1, 32'd44, 1, 32'd36);

    // Reset values while rstn is held low.
    mem_if.imem_gnt = 1'b1;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(mem_if.imem_req), 32'd0);
    check("rst_addr", mem_if.imem_addr, 32'h0);
    check("rst_fvalid", 32'(f_valid), 32'd0);
    check("rst_instruction", f_instruction, '0);
    check("rst_pc_plus4", f_pc_plus4, '0);
    rstn = 1'b1;

    // Streaming with 1-cycle memory, then a 10-cycle decode stall and drain.
    lat = 1;
    for (int i = 0; i < 21; i++) begin
      d_ready = vecs[i].d_ready;
      tick();
      check($sformatf("vec%0d_req", i), 32'(mem_if.imem_req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d_addr", i), mem_if.imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_fvalid", i), 32'(f_valid), 32'(vecs[i].exp_fvalid));
      check($sformatf("vec%0d_pc_plus4", i), f_pc_plus4, vecs[i].exp_pc4);
      check($sformatf("vec%0d_instr", i), f_instruction,
            vecs[i].exp_fvalid ? instr_of(vecs[i].exp_pc4 - 32'd4) : '0);
    end

    // 3-cycle memory, two requests in flight, redirect to 0x100 without a grant.
    apply_reset();
    lat = 3;
    repeat (3) tick();
    check("lat3_addr_before_redirect", mem_if.imem_addr, 32'd8);
    mem_if.imem_gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    mem_if.imem_gnt = 1'b1;
    check("flush_req_low", 32'(mem_if.imem_req), 32'd0);
    check("flush_addr", mem_if.imem_addr, 32'h100);
    check("flush_fvalid", 32'(f_valid), 32'd0);
    tick();
    check("flush_req_still_low", 32'(mem_if.imem_req), 32'd0);
    tick();
    check("refetch_req", 32'(mem_if.imem_req), 32'd1);
    check("refetch_addr", mem_if.imem_addr, 32'h100);
    wait_fvalid("redirect100_fvalid");
    check("redirect100_pc_plus4", f_pc_plus4, 32'h104);
    check("redirect100_instr", f_instruction, instr_of(32'h100));

    // Full FIFO, redirect together with a pop of the head.
    apply_reset();
    lat = 1;
    d_ready = 1'b0;
    repeat (10) tick();
    check("full_req_low", 32'(mem_if.imem_req), 32'd0);
    check("full_head_pc_plus4", f_pc_plus4, 32'd4);
    check("full_count", 32'(dut.fifo_count), 32'd4);
    d_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    check("redir_full_fvalid", 32'(f_valid), 32'd0);
    check("redir_full_req", 32'(mem_if.imem_req), 32'd1);
    check("redir_full_addr", mem_if.imem_addr, 32'h200);
    wait_fvalid("redirect200_fvalid");
    check("redirect200_pc_plus4", f_pc_plus4, 32'h204);

    // Redirect while pushing and popping in steady streaming.
    repeat (4) tick();
    check("stream_fvalid", 32'(f_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    check("redir_stream_fvalid", 32'(f_valid), 32'd0);
    check("redir_stream_req", 32'(mem_if.imem_req), 32'd0);
    wait_fvalid("redirect300_fvalid");
    check("redirect300_pc_plus4", f_pc_plus4, 32'h304);
    check("redirect300_instr", f_instruction, instr_of(32'h300));

    // Asynchronous reset in the middle of a flush.
    apply_reset();
    lat = 3;
    repeat (3) tick();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("midflush_req", 32'(mem_if.imem_req), 32'd0);
    rstn = 1'b0;
    #1;
    check("async_rst_req", 32'(mem_if.imem_req), 32'd0);
    check("async_rst_addr", mem_if.imem_addr, 32'h0);
    check("async_rst_fvalid", 32'(f_valid), 32'd0);
    check("async_rst_instruction", f_instruction, '0);
    check("async_rst_pc_plus4", f_pc_plus4, '0);
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    check("post_rst_req", 32'(mem_if.imem_req), 32'd1);
    check("post_rst_addr", mem_if.imem_addr, 32'h0);
    wait_fvalid("post_rst_fvalid");
    check("post_rst_pc_plus4", f_pc_plus4, 32'd4);
    check("post_rst_instr", f_instruction, instr_of(32'h0));

    // Randomised handshakes and redirects against the in-order scoreboard.
    apply_reset();
    exp_pc = 32'h0;
    pops = 0;
    rand_mode = 1'b1;
    sb_en = 1'b1;
    repeat (3000) tick();
    rand_mode = 1'b0;
    sb_en = 1'b0;
    redirect = 1'b0;
    check("random_enough_pops", 32'(pops > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
